// File: rtl/vga_scene_scanner_if.sv
// Scene read bus between the VGA scanner (master) and the game logic (slave).
// The master presents a board cell; the slave answers combinationally with
// occupancy of the committed matrix and the falling block, plus the
// next-block shape for the preview window.
interface vga_scene_scanner_if #(
    parameter int width_p  = 10,
    parameter int height_p = 20
);
    localparam int x_w_lp = (width_p  > 1) ? $clog2(width_p)  : 1;
    localparam int y_w_lp = (height_p > 1) ? $clog2(height_p) : 1;

    logic [x_w_lp-1:0] dis_logic_x;
    logic [y_w_lp-1:0] dis_logic_y;
    logic              dis_logic_mm;
    logic              dis_logic_cm;
    logic [3:0][3:0]   dis_logic_next_block;

    modport master (
        output dis_logic_x,
        output dis_logic_y,
        input  dis_logic_mm,
        input  dis_logic_cm,
        input  dis_logic_next_block
    );

    modport slave (
        input  dis_logic_x,
        input  dis_logic_y,
        output dis_logic_mm,
        output dis_logic_cm,
        output dis_logic_next_block
    );
endinterface

// File: rtl/vga_scene_scanner.sv
// VGA raster generator and scene reader. Counters walk the raster, stage 1
// decodes the pixel position into board/border/preview regions and presents
// the board cell to the game logic, stage 2 picks the colour from the
// returned cell data and registers it together with the syncs, so every
// output lags the counters by exactly two cycles.
module vga_scene_scanner #(
    parameter int width_p      = 10,
    parameter int height_p     = 20,
    parameter int cell_shift_p = 4,
    parameter int h_visible_p  = 640,
    parameter int h_front_p    = 16,
    parameter int h_sync_p     = 96,
    parameter int h_back_p     = 48,
    parameter int v_visible_p  = 480,
    parameter int v_front_p    = 10,
    parameter int v_sync_p     = 2,
    parameter int v_back_p     = 33,
    parameter int board_x0_p   = 240,
    parameter int board_y0_p   = 80,
    parameter int preview_x0_p = 480,
    parameter int preview_y0_p = 80
) (
    input  logic                clk_i,
    input  logic                reset_i,
    vga_scene_scanner_if.master scene,
    output logic                hsync_o,
    output logic                vsync_o,
    output logic [11:0]         rgb_o,
    output logic                active_o,
    output logic                frame_start_o
);

    localparam int h_total_lp = h_visible_p + h_front_p + h_sync_p + h_back_p;
    localparam int v_total_lp = v_visible_p + v_front_p + v_sync_p + v_back_p;
    localparam int h_w_lp     = $clog2(h_total_lp);
    localparam int v_w_lp     = $clog2(v_total_lp);
    localparam int x_w_lp     = (width_p  > 1) ? $clog2(width_p)  : 1;
    localparam int y_w_lp     = (height_p > 1) ? $clog2(height_p) : 1;
    localparam int cell_lp    = 1 << cell_shift_p;
    localparam int board_w_lp = width_p  << cell_shift_p;
    localparam int board_h_lp = height_p << cell_shift_p;
    localparam int prev_sz_lp = 4 << cell_shift_p;

    localparam logic [h_w_lp-1:0] h_last_lp      = h_w_lp'(h_total_lp - 1);
    localparam logic [v_w_lp-1:0] v_last_lp      = v_w_lp'(v_total_lp - 1);
    localparam logic [h_w_lp-1:0] h_vis_lp       = h_w_lp'(h_visible_p);
    localparam logic [v_w_lp-1:0] v_vis_lp       = v_w_lp'(v_visible_p);
    localparam logic [h_w_lp-1:0] hs_lo_lp       = h_w_lp'(h_visible_p + h_front_p);
    localparam logic [h_w_lp-1:0] hs_hi_lp       = h_w_lp'(h_visible_p + h_front_p + h_sync_p);
    localparam logic [v_w_lp-1:0] vs_lo_lp       = v_w_lp'(v_visible_p + v_front_p);
    localparam logic [v_w_lp-1:0] vs_hi_lp       = v_w_lp'(v_visible_p + v_front_p + v_sync_p);
    localparam logic [h_w_lp-1:0] board_x_lo_lp  = h_w_lp'(board_x0_p);
    localparam logic [h_w_lp-1:0] board_x_hi_lp  = h_w_lp'(board_x0_p + board_w_lp);
    localparam logic [v_w_lp-1:0] board_y_lo_lp  = v_w_lp'(board_y0_p);
    localparam logic [v_w_lp-1:0] board_y_hi_lp  = v_w_lp'(board_y0_p + board_h_lp);
    localparam logic [h_w_lp-1:0] border_x_lo_lp = h_w_lp'(board_x0_p - cell_lp);
    localparam logic [h_w_lp-1:0] border_x_hi_lp = h_w_lp'(board_x0_p + board_w_lp + cell_lp);
    localparam logic [v_w_lp-1:0] border_y_lo_lp = v_w_lp'(board_y0_p - cell_lp);
    localparam logic [v_w_lp-1:0] border_y_hi_lp = v_w_lp'(board_y0_p + board_h_lp + cell_lp);
    localparam logic [h_w_lp-1:0] prev_x_lo_lp   = h_w_lp'(preview_x0_p);
    localparam logic [h_w_lp-1:0] prev_x_hi_lp   = h_w_lp'(preview_x0_p + prev_sz_lp);
    localparam logic [v_w_lp-1:0] prev_y_lo_lp   = v_w_lp'(preview_y0_p);
    localparam logic [v_w_lp-1:0] prev_y_hi_lp   = v_w_lp'(preview_y0_p + prev_sz_lp);

    localparam bit overlap_lp =
        (preview_x0_p < board_x0_p + board_w_lp) && (board_x0_p < preview_x0_p + prev_sz_lp) &&
        (preview_y0_p < board_y0_p + board_h_lp) && (board_y0_p < preview_y0_p + prev_sz_lp);

    if (overlap_lp) begin : g_overlap_check
        $error("vga_scene_scanner: preview square overlaps the board rectangle");
    end

    logic [h_w_lp-1:0] h_cnt;
    logic [v_w_lp-1:0] v_cnt;

    logic [h_w_lp-1:0] h_rel_board;
    logic [v_w_lp-1:0] v_rel_board;
    logic [h_w_lp-1:0] h_rel_prev;
    logic [v_w_lp-1:0] v_rel_prev;
    logic              vis_c;
    logic              in_board_c;
    logic              in_border_box_c;
    logic              in_preview_c;
    logic              hsync_raw_c;
    logic              vsync_raw_c;
    logic              origin_c;

    logic              vis_q;
    logic              in_board_q;
    logic              in_border_q;
    logic              in_preview_q;
    logic [1:0]        prev_row_q;
    logic [1:0]        prev_col_q;
    logic              hsync_raw_q;
    logic              vsync_raw_q;
    logic              origin_q;

    // Raster counters: h wraps every line, v advances on each h wrap.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == h_last_lp) begin
            h_cnt <= '0;
            if (v_cnt == v_last_lp) begin
                v_cnt <= '0;
            end else begin
                v_cnt <= v_cnt + 1'b1;
            end
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign h_rel_board = h_cnt - board_x_lo_lp;
    assign v_rel_board = v_cnt - board_y_lo_lp;
    assign h_rel_prev  = h_cnt - prev_x_lo_lp;
    assign v_rel_prev  = v_cnt - prev_y_lo_lp;

    assign vis_c       = (h_cnt < h_vis_lp) && (v_cnt < v_vis_lp);
    assign in_board_c  = (h_cnt >= board_x_lo_lp) && (h_cnt < board_x_hi_lp) &&
                         (v_cnt >= board_y_lo_lp) && (v_cnt < board_y_hi_lp);
    assign in_border_box_c = (h_cnt >= border_x_lo_lp) && (h_cnt < border_x_hi_lp) &&
                             (v_cnt >= border_y_lo_lp) && (v_cnt < border_y_hi_lp);
    assign in_preview_c = (h_cnt >= prev_x_lo_lp) && (h_cnt < prev_x_hi_lp) &&
                          (v_cnt >= prev_y_lo_lp) && (v_cnt < prev_y_hi_lp);
    assign hsync_raw_c = (h_cnt >= hs_lo_lp) && (h_cnt < hs_hi_lp);
    assign vsync_raw_c = (v_cnt >= vs_lo_lp) && (v_cnt < vs_hi_lp);
    assign origin_c    = (h_cnt == '0) && (v_cnt == '0);

    // Stage 1: register region flags and present the board cell (0 outside the board).
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vis_q             <= 1'b0;
            in_board_q        <= 1'b0;
            in_border_q       <= 1'b0;
            in_preview_q      <= 1'b0;
            prev_row_q        <= '0;
            prev_col_q        <= '0;
            hsync_raw_q       <= 1'b0;
            vsync_raw_q       <= 1'b0;
            origin_q          <= 1'b0;
            scene.dis_logic_x <= '0;
            scene.dis_logic_y <= '0;
        end else begin
            vis_q        <= vis_c;
            in_board_q   <= in_board_c;
            in_border_q  <= in_border_box_c && !in_board_c;
            in_preview_q <= in_preview_c;
            prev_row_q   <= in_preview_c ? 2'(v_rel_prev >> cell_shift_p) : 2'b00;
            prev_col_q   <= in_preview_c ? 2'(h_rel_prev >> cell_shift_p) : 2'b00;
            hsync_raw_q  <= hsync_raw_c;
            vsync_raw_q  <= vsync_raw_c;
            origin_q     <= origin_c;
            if (in_board_c) begin
                scene.dis_logic_x <= x_w_lp'(h_rel_board >> cell_shift_p);
                scene.dis_logic_y <= y_w_lp'(v_rel_board >> cell_shift_p);
            end else begin
                scene.dis_logic_x <= '0;
                scene.dis_logic_y <= '0;
            end
        end
    end

    // Stage 2: choose the pixel colour by region priority and align the syncs with it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rgb_o         <= 12'h000;
            active_o      <= 1'b0;
            frame_start_o <= 1'b0;
            hsync_o       <= 1'b1;
            vsync_o       <= 1'b1;
        end else begin
            hsync_o       <= ~hsync_raw_q;
            vsync_o       <= ~vsync_raw_q;
            active_o      <= vis_q;
            frame_start_o <= origin_q;
            if (!vis_q) begin
                rgb_o <= 12'h000;
            end else if (in_board_q && scene.dis_logic_cm) begin
                rgb_o <= 12'hF00;
            end else if (in_board_q && scene.dis_logic_mm) begin
                rgb_o <= 12'hFFF;
            end else if (in_board_q) begin
                rgb_o <= 12'h111;
            end else if (in_border_q) begin
                rgb_o <= 12'h888;
            end else if (in_preview_q && scene.dis_logic_next_block[prev_row_q][prev_col_q]) begin
                rgb_o <= 12'h0F0;
            end else begin
                rgb_o <= 12'h000;
            end
        end
    end

endmodule

// File: tb/tb_vga_scene_scanner.sv
// Bench for vga_scene_scanner using a reduced raster (80x55 total, 4-pixel
// cells, 4x6 board) so several whole frames fit in a short run. A fixed
// scene is probed at hand-computed pixels, then random scene contents are
// checked every cycle against a pixel-arithmetic reference model.
module tb_vga_scene_scanner;

    localparam int width_lp   = 4;
    localparam int height_lp  = 6;
    localparam int shift_lp   = 2;
    localparam int cell_lp    = 4;
    localparam int hv_lp      = 64;
    localparam int hf_lp      = 4;
    localparam int hs_lp      = 8;
    localparam int hb_lp      = 4;
    localparam int vv_lp      = 48;
    localparam int vf_lp      = 2;
    localparam int vs_lp      = 2;
    localparam int vb_lp      = 3;
    localparam int bx0_lp     = 8;
    localparam int by0_lp     = 8;
    localparam int px0_lp     = 40;
    localparam int py0_lp     = 8;
    localparam int h_total_lp = hv_lp + hf_lp + hs_lp + hb_lp;
    localparam int v_total_lp = vv_lp + vf_lp + vs_lp + vb_lp;
    localparam int frame_lp   = h_total_lp * v_total_lp;
    localparam logic [15:0] reset_out_lp = 16'h000C;

    typedef struct {
        int         h;
        int         v;
        logic [11:0] rgb;
        logic       hs;
        logic       vs;
        logic       act;
        logic       fs;
        logic [1:0] x;
        logic [2:0] y;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        hsync_o;
    logic        vsync_o;
    logic [11:0] rgb_o;
    logic        active_o;
    logic        frame_start_o;

    logic [31:0] mm_map = '0;
    logic [31:0] cm_map = '0;
    logic [15:0] nb_map = '0;

    int vectors = 0;
    int miscompares = 0;
    int edges = 0;
    vec_t vecs[$];

    vga_scene_scanner_if #(.width_p(width_lp), .height_p(height_lp)) scene();

    vga_scene_scanner #(
        .width_p(width_lp), .height_p(height_lp), .cell_shift_p(shift_lp),
        .h_visible_p(hv_lp), .h_front_p(hf_lp), .h_sync_p(hs_lp), .h_back_p(hb_lp),
        .v_visible_p(vv_lp), .v_front_p(vf_lp), .v_sync_p(vs_lp), .v_back_p(vb_lp),
        .board_x0_p(bx0_lp), .board_y0_p(by0_lp),
        .preview_x0_p(px0_lp), .preview_y0_p(py0_lp)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .scene(scene),
        .hsync_o(hsync_o),
        .vsync_o(vsync_o),
        .rgb_o(rgb_o),
        .active_o(active_o),
        .frame_start_o(frame_start_o)
    );

    always #5 clk_i = ~clk_i;

    // Game-logic stand-in: cell occupancy looked up combinationally from the presented cell.
    always_comb begin
        scene.dis_logic_mm         = mm_map[{scene.dis_logic_y, scene.dis_logic_x}];
        scene.dis_logic_cm         = cm_map[{scene.dis_logic_y, scene.dis_logic_x}];
        scene.dis_logic_next_block = nb_map;
    end

    function automatic logic [15:0] model_pixel(int p, logic [31:0] mm, logic [31:0] cm,
                                                logic [15:0] nb);
        int h, v, bx, by, px, py, idx;
        bit board, border, prev, act, hs, vs, fs;
        logic [11:0] rgb;
        h = p % h_total_lp;
        v = (p / h_total_lp) % v_total_lp;
        bx = h - bx0_lp;
        by = v - by0_lp;
        px = h - px0_lp;
        py = v - py0_lp;
        board  = bx >= 0 && bx < width_lp * cell_lp && by >= 0 && by < height_lp * cell_lp;
        border = !board && bx >= -cell_lp && bx < (width_lp + 1) * cell_lp &&
                 by >= -cell_lp && by < (height_lp + 1) * cell_lp;
        prev   = px >= 0 && px < 4 * cell_lp && py >= 0 && py < 4 * cell_lp;
        act = h < hv_lp && v < vv_lp;
        hs  = !(h >= hv_lp + hf_lp && h < hv_lp + hf_lp + hs_lp);
        vs  = !(v >= vv_lp + vf_lp && v < vv_lp + vf_lp + vs_lp);
        fs  = h == 0 && v == 0;
        rgb = 12'h000;
        if (act) begin
            if (board) begin
                idx = (by / cell_lp) * 4 + bx / cell_lp;
                if (cm[idx])      rgb = 12'hF00;
                else if (mm[idx]) rgb = 12'hFFF;
                else              rgb = 12'h111;
            end else if (border) begin
                rgb = 12'h888;
            end else if (prev && nb[(py / cell_lp) * 4 + px / cell_lp]) begin
                rgb = 12'h0F0;
            end
        end
        return {rgb, hs, vs, act, fs};
    endfunction

    function automatic logic [4:0] model_xy(int p);
        int h, v, bx, by;
        h = p % h_total_lp;
        v = (p / h_total_lp) % v_total_lp;
        bx = h - bx0_lp;
        by = v - by0_lp;
        if (bx >= 0 && bx < width_lp * cell_lp && by >= 0 && by < height_lp * cell_lp)
            return {2'(bx / cell_lp), 3'(by / cell_lp)};
        return 5'b0;
    endfunction

    task automatic applyStimulus();
        @(posedge clk_i);
        #1;
        if (!reset_i) edges++;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at edge %0d: got %h, expected %h", name, edges, actual, expected);
        end
    endtask

    task automatic checkReset(input string name);
        checkOutput({name, "_outputs"}, 32'({rgb_o, hsync_o, vsync_o, active_o, frame_start_o}),
                    32'(reset_out_lp));
        checkOutput({name, "_xy"}, 32'({scene.dis_logic_x, scene.dis_logic_y}), 32'd0);
    endtask

    task automatic runModel(input int n);
        int p;
        logic [15:0] exp_out;
        for (int i = 0; i < n; i++) begin
            applyStimulus();
            p = edges - 2;
            exp_out = (p < 0) ? reset_out_lp : model_pixel(p, mm_map, cm_map, nb_map);
            checkOutput("pixel", 32'({rgb_o, hsync_o, vsync_o, active_o, frame_start_o}),
                        32'(exp_out));
            checkOutput("xy", 32'({scene.dis_logic_x, scene.dis_logic_y}), 32'(model_xy(edges - 1)));
            mm_map = $urandom();
            cm_map = $urandom() & $urandom() & $urandom();
            nb_map = 16'($urandom());
        end
    endtask

    task automatic addVec(input int h, input int v, input logic [11:0] rgb, input logic hs,
                          input logic vs, input logic act, input logic fs, input logic [1:0] x,
                          input logic [2:0] y);
        vec_t e;
        e.h = h; e.v = v; e.rgb = rgb; e.hs = hs; e.vs = vs; e.act = act; e.fs = fs;
        e.x = x; e.y = y;
        vecs.push_back(e);
    endtask

    initial begin
        #(10 * 60000);
        $display("[TB] FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int last_p;
        int p;

        addVec( 0,  0, 12'h000, 1, 1, 1, 1, 0, 0);
        addVec(67,  0, 12'h000, 1, 1, 0, 0, 0, 0);
        addVec(68,  0, 12'h000, 0, 1, 0, 0, 0, 0);
        addVec(75,  0, 12'h000, 0, 1, 0, 0, 0, 0);
        addVec(76,  0, 12'h000, 1, 1, 0, 0, 0, 0);
        addVec( 8,  8, 12'h111, 1, 1, 1, 0, 0, 0);
        addVec(23,  8, 12'h111, 1, 1, 1, 0, 3, 0);
        addVec(24,  8, 12'h888, 1, 1, 1, 0, 0, 0);
        addVec(40,  8, 12'h000, 1, 1, 1, 0, 0, 0);
        addVec(48, 12, 12'h0F0, 1, 1, 1, 0, 0, 0);
        addVec(52, 12, 12'h000, 1, 1, 1, 0, 0, 0);
        addVec(51, 15, 12'h0F0, 1, 1, 1, 0, 0, 0);
        addVec(12, 16, 12'hFFF, 1, 1, 1, 0, 1, 2);
        addVec(16, 16, 12'h111, 1, 1, 1, 0, 2, 2);
        addVec(15, 19, 12'hFFF, 1, 1, 1, 0, 1, 2);
        addVec( 7, 20, 12'h888, 1, 1, 1, 0, 0, 0);
        addVec(20, 28, 12'hF00, 1, 1, 1, 0, 3, 5);
        addVec(23, 31, 12'hF00, 1, 1, 1, 0, 3, 5);
        addVec(24, 32, 12'h888, 1, 1, 1, 0, 0, 0);
        addVec(27, 35, 12'h888, 1, 1, 1, 0, 0, 0);
        addVec(28, 35, 12'h000, 1, 1, 1, 0, 0, 0);
        addVec(63, 47, 12'h000, 1, 1, 1, 0, 0, 0);
        addVec(79, 49, 12'h000, 1, 1, 0, 0, 0, 0);
        addVec( 0, 50, 12'h000, 1, 0, 0, 0, 0, 0);
        addVec( 0, 52, 12'h000, 1, 1, 0, 0, 0, 0);

        // Fixed scene: mm at cell (1,2); mm and cm at cell (3,5); preview bit [1][2].
        mm_map = 32'h0;
        mm_map[2 * 4 + 1] = 1'b1;
        mm_map[5 * 4 + 3] = 1'b1;
        cm_map = 32'h0;
        cm_map[5 * 4 + 3] = 1'b1;
        nb_map = 16'h0;
        nb_map[1 * 4 + 2] = 1'b1;

        reset_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkReset("reset_hold");
        end
        reset_i = 1'b0;
        edges = 0;

        last_p = 0;
        foreach (vecs[i]) begin
            p = vecs[i].v * h_total_lp + vecs[i].h;
            if (p > last_p) last_p = p;
        end
        while (edges < last_p + 2) begin
            applyStimulus();
            foreach (vecs[i]) begin
                p = vecs[i].v * h_total_lp + vecs[i].h;
                if (edges == p + 1)
                    checkOutput($sformatf("xy(%0d,%0d)", vecs[i].h, vecs[i].v),
                                32'({scene.dis_logic_x, scene.dis_logic_y}),
                                32'({vecs[i].x, vecs[i].y}));
                if (edges == p + 2)
                    checkOutput($sformatf("pix(%0d,%0d)", vecs[i].h, vecs[i].v),
                                32'({rgb_o, hsync_o, vsync_o, active_o, frame_start_o}),
                                32'({vecs[i].rgb, vecs[i].hs, vecs[i].vs, vecs[i].act, vecs[i].fs}));
            end
        end

        runModel(2 * frame_lp + 30 * h_total_lp + 37 - edges);

        reset_i = 1'b1;
        applyStimulus();
        checkReset("midline_reset");
        applyStimulus();
        checkReset("midline_hold");
        reset_i = 1'b0;
        edges = 0;
        runModel(frame_lp + 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
